// File: rtl/cdbus_rx_fetch_if.sv
// CSR initiator bus and outgoing byte stream between the cdbus fetcher and its neighbours.
interface cdbus_rx_fetch_if;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (
    output csr_address, csr_read, csr_write, csr_writedata, m_data, m_valid, m_last,
    input  csr_readdata, m_ready
  );

  modport slave (
    input  csr_address, csr_read, csr_write, csr_writedata, m_data, m_valid, m_last,
    output csr_readdata, m_ready
  );
endinterface

// File: rtl/cdbus_rx_fetch.sv
// Drains received cdbus frames through the controller CSR port and streams them out
// as ready/valid bytes. Polls INT_FLAG (or reacts to irq), reads one RX page, releases it.
module cdbus_rx_fetch #(
  parameter logic [4:0] REG_INT_FLAG     = 5'h10,
  parameter logic [4:0] REG_RX           = 5'h14,
  parameter logic [4:0] REG_RX_CTRL      = 5'h16,
  parameter int         RX_PENDING_BIT   = 1,
  parameter int         RX_LOST_BIT      = 3,
  parameter logic [7:0] CTRL_RST_PTR     = 8'h01,
  parameter logic [7:0] CTRL_CLR_PENDING = 8'h02,
  parameter logic [7:0] CTRL_CLR_LOST    = 8'h04,
  parameter int         POLL_GAP         = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    irq,
  cdbus_rx_fetch_if.master        bus,
  output logic [7:0]              rx_lost_cnt,
  output logic [15:0]             frame_cnt,
  output logic                    busy
);

  // state     | meaning
  // IDLE      | waiting out the poll gap (counts only while enabled)
  // POLL      | read strobe to INT_FLAG
  // POLL_W    | evaluate INT_FLAG read data
  // CLR_LOST  | write CLR_LOST to RX_CTRL
  // RST_PTR   | write RST_PTR to RX_CTRL, start a frame
  // RD        | read strobe to RX data register
  // RD_W      | capture byte, present it on the stream
  // OUT       | hold byte until the sink accepts it
  // DONE      | write CLR_PENDING to RX_CTRL, count the frame
  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_POLL_W, S_CLR_LOST, S_RST_PTR, S_RD, S_RD_W, S_OUT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] poll_cnt;
  logic [7:0]  idx;
  logic [8:0]  total;
  logic [8:0]  total_upd;
  logic [7:0]  data_q;
  logic        valid_q, last_q;
  logic [4:0]  addr_q, addr_c;
  logic [7:0]  wdata_q, wdata_c;
  logic        rd_c, wr_c;
  logic        poll_go;

  // Transition happens on the cycle the counter would reach zero, giving POLL_GAP idle cycles.
  assign poll_go = irq || (poll_cnt <= 16'd1);

  // Length byte sits at index 2; 3 header bytes plus at most 253 payload bytes.
  always_comb begin
    total_upd = total;
    if (idx == 8'd2)
      total_upd = 9'd3 + ((bus.csr_readdata > 8'd253) ? 9'd253 : {1'b0, bus.csr_readdata});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      poll_cnt    <= 16'(POLL_GAP);
      idx         <= '0;
      total       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_lost_cnt <= '0;
      frame_cnt   <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_c;
      wdata_q <= wdata_c;
      case (state)
        S_IDLE:    if (enable && !poll_go) poll_cnt <= poll_cnt - 16'd1;
        S_POLL_W: begin
          if (bus.csr_readdata[RX_LOST_BIT]) begin
            if (rx_lost_cnt != 8'hFF) rx_lost_cnt <= rx_lost_cnt + 8'd1;
          end else if (!bus.csr_readdata[RX_PENDING_BIT]) begin
            poll_cnt <= 16'(POLL_GAP);
          end
        end
        S_RST_PTR: begin
          idx   <= '0;
          total <= 9'd3;
        end
        S_RD_W: begin
          data_q  <= bus.csr_readdata;
          valid_q <= 1'b1;
          total   <= total_upd;
          last_q  <= ({1'b0, idx} == (total_upd - 9'd1));
        end
        S_OUT: begin
          if (bus.m_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (!last_q) idx <= idx + 8'd1;
          end
        end
        S_DONE: begin
          frame_cnt <= frame_cnt + 16'd1;
          poll_cnt  <= 16'(POLL_GAP);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable && poll_go) state_nxt = S_POLL;
      S_POLL:     state_nxt = S_POLL_W;
      S_POLL_W: begin
        if (bus.csr_readdata[RX_LOST_BIT])         state_nxt = S_CLR_LOST;
        else if (bus.csr_readdata[RX_PENDING_BIT]) state_nxt = S_RST_PTR;
        else                                       state_nxt = S_IDLE;
      end
      S_CLR_LOST: state_nxt = S_POLL;
      S_RST_PTR:  state_nxt = S_RD;
      S_RD:       state_nxt = S_RD_W;
      S_RD_W:     state_nxt = S_OUT;
      S_OUT:      if (bus.m_ready) state_nxt = last_q ? S_DONE : S_RD;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Address and write data only change with a strobe; otherwise the last value is held.
  always_comb begin
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    addr_c  = addr_q;
    wdata_c = wdata_q;
    case (state)
      S_POLL:     begin rd_c = 1'b1; addr_c = REG_INT_FLAG; end
      S_RD:       begin rd_c = 1'b1; addr_c = REG_RX; end
      S_CLR_LOST: begin wr_c = 1'b1; addr_c = REG_RX_CTRL; wdata_c = CTRL_CLR_LOST; end
      S_RST_PTR:  begin wr_c = 1'b1; addr_c = REG_RX_CTRL; wdata_c = CTRL_RST_PTR; end
      S_DONE:     begin wr_c = 1'b1; addr_c = REG_RX_CTRL; wdata_c = CTRL_CLR_PENDING; end
      default: ;
    endcase
  end

  assign bus.csr_read      = rd_c;
  assign bus.csr_write     = wr_c;
  assign bus.csr_address   = addr_c;
  assign bus.csr_writedata = wdata_c;
  assign bus.m_data        = data_q;
  assign bus.m_valid       = valid_q;
  assign bus.m_last        = last_q;
  assign busy              = (state != S_IDLE);

endmodule

// File: doc/cdbus_rx_fetch.md
Name: cdbus_rx_fetch

Overview:
- CSR initiator that drains received frames out of a cdbus controller and presents them as a byte stream with ready/valid backpressure.
- Drives the controller's 5-bit csr_address / csr_read / csr_write bus.
- Sits between the cdbus instance and host-side logic (FIFO, DMA or packet router).
- Polls or waits on the controller irq, reads one RX page byte by byte, then releases the page.

Parameters:
REG_INT_FLAG, 5'h10, address of interrupt flag register
REG_RX, 5'h14, RX data register (auto-increment read pointer)
REG_RX_CTRL, 5'h16, RX control register
RX_PENDING_BIT, 1, bit index of rx-pending in INT_FLAG
RX_LOST_BIT, 3, bit index of rx-lost in INT_FLAG
CTRL_RST_PTR, 8'h01, RX_CTRL value that resets the read pointer
CTRL_CLR_PENDING, 8'h02, RX_CTRL value that releases the page
CTRL_CLR_LOST, 8'h04, RX_CTRL value that clears rx-lost
POLL_GAP, 16, idle cycles between INT_FLAG polls

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  1: fetch frames; 0: stop at next frame boundary
irq  in  1  controller interrupt; skips the remaining poll gap
csr_address  out  5  CSR address
csr_read  out  1  read strobe, 1-cycle pulse
csr_readdata  in  8  read data, valid 1 cycle after csr_read
csr_write  out  1  write strobe, 1-cycle pulse
csr_writedata  out  8  write data, valid with csr_write
m_data  out  8  frame byte
m_valid  out  1  m_data valid
m_ready  in  1  sink accepts byte
m_last  out  1  last byte of frame, qualified by m_valid
rx_lost_cnt  out  8  saturating count of rx-lost events
frame_cnt  out  16  wrapping count of completed frames
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; poll counter loaded with POLL_GAP.
- csr_read and csr_write are never high in the same cycle. Each is a single-cycle pulse.
- csr_address and csr_writedata are held stable until the next strobe.
- Read data is sampled exactly one cycle after csr_read.
- States:
  - IDLE: if enable, count the poll counter down. At 0 or on irq, go to POLL.
  - POLL: issue read of REG_INT_FLAG, then go to POLL_W.
  - POLL_W: sample csr_readdata.
    - If RX_LOST_BIT is set: rx_lost_cnt+1 (saturate at 255), then CLR_LOST.
    - Else if RX_PENDING_BIT is set: go to RST_PTR.
    - Else: reload the poll counter and return to IDLE.
  - CLR_LOST: write CTRL_CLR_LOST to REG_RX_CTRL, then go to POLL.
  - RST_PTR: write CTRL_RST_PTR to REG_RX_CTRL; set idx=0 and total=3; go to RD.
  - RD: issue read of REG_RX, then go to RD_W.
  - RD_W: latch the byte into m_data and assert m_valid.
    - If idx==2: total = 3 + min(byte, 253).
    - m_last = (idx == total-1), using the updated total.
    - Go to OUT.
  - OUT: hold m_data, m_valid and m_last until m_ready. On the handshake cycle:
    - Deassert m_valid and increment idx.
    - If m_last: go to DONE. Else go to RD.
  - DONE: write CTRL_CLR_PENDING to REG_RX_CTRL; frame_cnt+1; reload the poll counter; go to IDLE.
- Throughput: 3 cycles per byte with m_ready held high (RD, RD_W, OUT).
- idx is 8 bits. The maximum frame is 256 bytes; idx never wraps.
- enable deasserted mid-frame: the current frame completes through DONE. No new POLL starts while enable=0.
- irq during OUT/RD is ignored; it is re-evaluated only in IDLE.
- A len byte of 254 or 255 is clamped so total=256; m_last lands on idx 255.
- reset mid-frame: return immediately to IDLE with outputs cleared. No RX_CTRL write is issued; the page stays pending and is re-read from byte 0 after reset.

Test Plan:
- INT_FLAG=0x00 held, enable=1 -> a csr_read of 0x10 every POLL_GAP+2 cycles; no csr_write; m_valid stays 0.
- Pending frame {0x01,0x02,0x03,0xAA,0xBB,0xCC}, m_ready=1 -> writes 0x16←0x01; six reads of 0x14; m_data sequence 01,02,03,AA,BB,CC with m_last only on CC; write 0x16←0x02; frame_cnt=1.
- Same frame with m_ready toggling 1/0 each cycle -> identical byte order; m_data and m_last stable while m_valid&&!m_ready; no csr_read issued during a stall.
- INT_FLAG=0x08 then 0x02 -> write 0x16←0x04 first, rx_lost_cnt=1, then the frame fetch proceeds; 256 lost events -> rx_lost_cnt holds 255.
- len byte=0x00 -> exactly 3 bytes out, m_last on byte 2. len byte=0xFF -> 256 bytes out, m_last on byte 255.
- reset asserted in OUT at byte 4 -> next cycle m_valid=0 and busy=0; after release the next fetch writes RST_PTR and replays from byte 0.
